axi_lite_pwm_multi: RTL and testbench

//  Multi-channel PWM generator with a full AXI4-Lite slave (write + read). Each channel has
//  its own control, period and duty registers. Period/duty are double-buffered: new values

---
 rtl/axi_lite_pwm_pkg.sv | 30 +++
 rtl/axi_lite_pwm_multi_channel.sv | 57 +++++
 rtl/axi_lite_pwm_multi.sv | 205 ++++++++++++++++++++
 tb/tb_axi_lite_pwm_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pwm_pkg.sv
// Shared definitions for the AXI4-Lite multi-channel PWM block: register map,
// response codes, bus FSM state types and the byte-strobe merge helper.
package axi_lite_pwm_pkg;

    // Word offsets within a channel's 16-byte window (address bits [3:2]).
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_pwm_multi_channel.sv
// One PWM channel: double-buffered period/duty taken from the shadow registers
// at the period boundary (or continuously while idle), registered output pin.
module pwm_channel
    import axi_lite_pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             invert,
    input  logic [CNT_W-1:0] period_shadow,
    input  logic [CNT_W-1:0] duty_shadow,
    output logic             pwm,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pwm_q;
    logic             last_cycle;
    logic             period_zero;
    logic             load;
    logic             raw;

    assign period_zero = (period_q == '0);
    assign last_cycle  = !period_zero && (cnt_q == period_q - CNT_W'(1));
    // A zero period has no boundary to wait for, so it keeps tracking the shadows.
    assign load        = !enable || period_zero || last_cycle;
    assign raw         = !period_zero && (cnt_q < duty_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            pwm_q    <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            if (load) begin
                period_q <= period_shadow;
                duty_q   <= duty_shadow;
            end
            if (!enable || period_zero || last_cycle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            pwm_q <= enable ? (raw ^ invert) : invert;
        end
    end

    assign pwm   = pwm_q;
    assign count = cnt_q;

endmodule

// File: rtl/axi_lite_pwm_multi.sv
// AXI4-Lite slave with N_CH PWM channels: independent write and read FSMs,
// address decode with SLVERR on unmapped/unaligned/read-only targets, byte strobes.
module axi_lite_pwm_multi
    import axi_lite_pwm_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              axi_lite_aclk,
    input  logic              axi_lite_areset,
    output logic [N_CH-1:0]   pwm,
    input  logic [ADDR_W-1:0] axi_lite_awaddr,
    input  logic              axi_lite_awvalid,
    output logic              axi_lite_awready,
    input  logic [31:0]       axi_lite_wdata,
    input  logic [3:0]        axi_lite_wstrb,
    input  logic              axi_lite_wvalid,
    output logic              axi_lite_wready,
    output logic [1:0]        axi_lite_bresp,
    output logic              axi_lite_bvalid,
    input  logic              axi_lite_bready,
    input  logic [ADDR_W-1:0] axi_lite_araddr,
    input  logic              axi_lite_arvalid,
    output logic              axi_lite_arready,
    output logic [31:0]       axi_lite_rdata,
    output logic [1:0]        axi_lite_rresp,
    output logic              axi_lite_rvalid,
    input  logic              axi_lite_rready
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic [1:0]        ctrl   [N_CH];
    logic [CNT_W-1:0]  period [N_CH];
    logic [CNT_W-1:0]  duty   [N_CH];
    logic [CNT_W-1:0]  count  [N_CH];
    logic [31:0]       words  [N_CH][4];

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [CH_W-1:0]   wr_ch, rd_ch;
    logic [1:0]        wr_off, rd_off;
    logic              wr_ok, rd_ok;
    logic [31:0]       wr_old, wr_merged, rd_word;

    assign aw_hs  = axi_lite_awvalid && axi_lite_awready;
    assign w_hs   = axi_lite_wvalid && axi_lite_wready;
    assign ar_hs  = axi_lite_arvalid && axi_lite_arready;
    assign commit = (wr_state == W_IDLE) && aw_held && w_held;

    assign wr_ch  = awaddr_q[4 +: CH_W];
    assign wr_off = awaddr_q[3:2];
    assign wr_ok  = (awaddr_q[1:0] == 2'b00) && (32'(awaddr_q) < 32'(16 * N_CH))
                    && (wr_off != REG_COUNT);
    assign rd_ch  = axi_lite_araddr[4 +: CH_W];
    assign rd_off = axi_lite_araddr[3:2];
    assign rd_ok  = (axi_lite_araddr[1:0] == 2'b00)
                    && (32'(axi_lite_araddr) < 32'(16 * N_CH));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_old = '0;
        rd_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            words[i][REG_CTRL]   = {30'b0, ctrl[i]};
            words[i][REG_PERIOD] = 32'(period[i]);
            words[i][REG_DUTY]   = 32'(duty[i]);
            words[i][REG_COUNT]  = 32'(count[i]);
            if (wr_ch == CH_W'(i)) wr_old = words[i][wr_off];
            if (rd_ch == CH_W'(i)) rd_word = words[i][rd_off];
        end
    end

    assign wr_merged = merge_wstrb(wr_old, wdata_q, wstrb_q);

    // Write FSM: state register, next state, outputs.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) wr_state <= W_IDLE;
        else                 wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (commit) wr_next = W_RESP;
            W_RESP:  if (axi_lite_bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        axi_lite_awready = (wr_state == W_IDLE) && !aw_held;
        axi_lite_wready  = (wr_state == W_IDLE) && !w_held;
        axi_lite_bvalid  = (wr_state == W_RESP);
    end

    // AW and W are captured independently and released together at commit.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= axi_lite_awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= axi_lite_wdata;
                wstrb_q <= axi_lite_wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            // NOTE: the register file is a handful of flops, so each entry is reset explicitly.
            for (int i = 0; i < N_CH; i++) begin
                ctrl[i]   <= '0;
                period[i] <= '0;
                duty[i]   <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_ch == CH_W'(i)) begin
                    case (wr_off)
                        REG_CTRL:   ctrl[i]   <= wr_merged[1:0];
                        REG_PERIOD: period[i] <= wr_merged[CNT_W-1:0];
                        REG_DUTY:   duty[i]   <= wr_merged[CNT_W-1:0];
                        default:    ;
                    endcase
                end
            end
        end
    end

    assign axi_lite_bresp = bresp_q;

    // Read FSM: state register, next state, outputs.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) rd_state <= R_IDLE;
        else                 rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            R_DATA:  if (axi_lite_rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        axi_lite_arready = (rd_state == R_IDLE);
        axi_lite_rvalid  = (rd_state == R_DATA);
    end

    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_ok ? rd_word : 32'h0;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign axi_lite_rdata = rdata_q;
    assign axi_lite_rresp = rresp_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk           (axi_lite_aclk),
            .rst           (axi_lite_areset),
            .enable        (ctrl[i][CTRL_EN]),
            .invert        (ctrl[i][CTRL_INV]),
            .period_shadow (period[i]),
            .duty_shadow   (duty[i]),
            .pwm           (pwm[i]),
            .count         (count[i])
        );
    end

endmodule

// File: tb/tb_axi_lite_pwm_multi.sv
// Directed bench for axi_lite_pwm_multi: bus handshakes, error responses,
// double-buffered waveforms, boundary duty/period cases and async reset.
module tb_axi_lite_pwm_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 12;
    localparam int TMO    = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   pwm;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] s2;
    logic [31:0] e2;
    int          n_hold;

    always #5 clk = ~clk;

    axi_lite_pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .axi_lite_aclk    (clk),
        .axi_lite_areset  (rst),
        .pwm              (pwm),
        .axi_lite_awaddr  (awaddr),
        .axi_lite_awvalid (awvalid),
        .axi_lite_awready (awready),
        .axi_lite_wdata   (wdata),
        .axi_lite_wstrb   (wstrb),
        .axi_lite_wvalid  (wvalid),
        .axi_lite_wready  (wready),
        .axi_lite_bresp   (bresp),
        .axi_lite_bvalid  (bvalid),
        .axi_lite_bready  (bready),
        .axi_lite_araddr  (araddr),
        .axi_lite_arvalid (arvalid),
        .axi_lite_arready (arready),
        .axi_lite_rdata   (rdata),
        .axi_lite_rresp   (rresp),
        .axi_lite_rvalid  (rvalid),
        .axi_lite_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] dat,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int n = 0;
        awaddr = a; wdata = dat; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < TMO) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk); n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("wr_timeout", 32'(bvalid), 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] dat, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("rd_timeout", 32'(rvalid), 32'd1);
        dat = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wait_rise(input int ch);
        logic prev;
        int n = 0;
        prev = pwm[ch];
        @(negedge clk);
        while (!(pwm[ch] && !prev) && n < TMO) begin
            prev = pwm[ch];
            @(negedge clk); n++;
        end
    endtask

    // Align on a rising edge, then expect hi samples high and lo samples low, twice.
    task automatic wave(input string tag, input int ch, input int hi, input int lo);
        logic [31:0] got = '0;
        logic [31:0] exp = '0;
        wait_rise(ch);
        for (int k = 0; k < 2 * (hi + lo); k++) begin
            got[k] = pwm[ch];
            exp[k] = ((k % (hi + lo)) < hi);
            @(negedge clk);
        end
        check(tag, got, exp);
    endtask

    task automatic steady(input string tag, input int ch, input logic val);
        logic [31:0] got = '0;
        logic [31:0] exp = '0;
        for (int k = 0; k < 20; k++) begin
            got[k] = pwm[ch];
            exp[k] = val;
            @(negedge clk);
        end
        check(tag, got, exp);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_pwm", pwm, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {bresp, rresp}, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic waveform on channel 0.
        axi_write(12'h004, 32'd10, 4'hF, r); check("t1_bresp_period", r, 2'b00);
        axi_write(12'h008, 32'd3, 4'hF, r);  check("t1_bresp_duty", r, 2'b00);
        axi_write(12'h000, 32'd1, 4'hF, r);  check("t1_bresp_ctrl", r, 2'b00);
        wave("t1_wave_3_7", 0, 3, 7);

        // Duty change mid-period takes effect only at the next period.
        wait_rise(0);
        fork
            begin
                for (int k = 0; k < 20; k++) begin s2[k] = pwm[0]; @(negedge clk); end
            end
            begin
                @(negedge clk);
                axi_write(12'h008, 32'd7, 4'hF, r);
            end
        join
        e2 = '0;
        for (int k = 0; k < 20; k++) e2[k] = (k < 3) || (k >= 10 && k < 17);
        check("t2_duty_switch", s2, e2);
        check("t2_bresp", r, 2'b00);

        // W two cycles before AW, with a stalled response on channel 1.
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk); wvalid = 1'b0;
        check("t3_w_first", {awready, wready}, 2'b10);
        @(negedge clk); awaddr = 12'h014; awvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        check("t3_both_held", {awready, wready, bvalid}, 3'b000);
        @(negedge clk);
        check("t3_bvalid", {bvalid, bresp}, 3'b100);
        n_hold = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bvalid && !awready && !wready) n_hold++;
        end
        check("t3_bhold", n_hold, 5);
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        check("t3_release", {awready, wready, bvalid}, 3'b110);
        axi_read(12'h014, d, r); check("t3_period_rb", d, 32'h55);

        // AW and W in the same cycle.
        awaddr = 12'h018; wdata = 32'h22; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        check("t3s_held", {awready, wready, bvalid}, 3'b000);
        @(negedge clk);
        check("t3s_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
        check("t3s_release", {awready, wready, bvalid}, 3'b110);
        axi_read(12'h018, d, r); check("t3s_duty_rb", d, 32'h22);

        // Error responses without side effects.
        axi_write(12'h040, 32'h99, 4'hF, r); check("t4_oob_bresp", r, 2'b10);
        axi_write(12'h00C, 32'h99, 4'hF, r); check("t4_count_bresp", r, 2'b10);
        axi_write(12'h005, 32'h99, 4'hF, r); check("t4_unaligned_bresp", r, 2'b10);
        axi_read(12'h004, d, r); check("t4_period_kept", d, 32'd10); check("t4_rresp_ok", r, 2'b00);
        axi_read(12'h008, d, r); check("t4_duty_kept", d, 32'd7);
        axi_read(12'hFFE, d, r); check("t4_bad_rresp", r, 2'b10); check("t4_bad_rdata", d, 32'h0);
        axi_read(12'h00C, d, r); check("t4_count_rresp", r, 2'b00);

        // Boundary cases on channel 2.
        axi_write(12'h024, 32'd10, 4'hF, r);
        axi_write(12'h028, 32'd0, 4'hF, r);
        axi_write(12'h020, 32'd1, 4'hF, r);
        steady("t5_duty0_low", 2, 1'b0);
        axi_write(12'h028, 32'd12, 4'hF, r);
        repeat (12) @(negedge clk);
        steady("t5_duty_gt_period_high", 2, 1'b1);
        axi_write(12'h024, 32'd0, 4'hF, r);
        repeat (12) @(negedge clk);
        steady("t5_period0_low", 2, 1'b0);
        axi_write(12'h020, 32'd0, 4'hF, r);
        axi_write(12'h024, 32'd10, 4'hF, r);
        axi_write(12'h028, 32'd3, 4'hF, r);
        axi_write(12'h020, 32'd3, 4'hF, r);
        wave("t5_inverted", 2, 7, 3);
        axi_write(12'h020, 32'd2, 4'hF, r);
        repeat (2) @(negedge clk);
        steady("t5_idle_high", 2, 1'b1);

        // Byte strobes and reset during a pending response on channel 3.
        axi_write(12'h034, 32'h100, 4'hF, r);
        axi_write(12'h034, 32'hAABBCCDD, 4'b0001, r);
        axi_read(12'h034, d, r); check("t6_wstrb_merge", d, 32'h1DD);
        awaddr = 12'h038; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("t6_pre_rst", {bvalid, pwm[2]}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("t6_async_bvalid", bvalid, 1'b0);
        check("t6_async_pwm", pwm, 4'h0);
        check("t6_async_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        axi_read(12'h034, d, r); check("t6_reg_cleared", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
